// File: rtl/bcd_share_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_share_ctrl
//
// Shares one external combinational binary-to-BCD divider between the
// seconds, minutes and hours requesters. Requests are served round-robin.
// The granted channel's 6-bit value is latched and driven on div_bin. It is
// held there for SETTLE cycles. The divider's two digits are then captured
// into that channel's result register. Values above MAX_VAL are not stored;
// they are reported with range_err instead.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   req[2:0]              : level requests, [0]=sec [1]=min [2]=hour
//   bin_sec/min/hour[5:0] : binary values of the three channels
//   div_bin[5:0]          : operand driven to the divider
//   div_bcd_h/l[3:0]      : tens / units digits returned by the divider
//   ack[2:0]              : one-cycle one-hot completion pulse
//   range_err             : pulses with ack when the operand exceeded MAX_VAL
//   sec/min/hour_bcd[7:0] : {tens,units} result registers
//   busy                  : high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module bcd_share_ctrl #(
    parameter int SETTLE  = 1,
    parameter int MAX_VAL = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [5:0] bin_sec,
    input  logic [5:0] bin_min,
    input  logic [5:0] bin_hour,
    output logic [5:0] div_bin,
    input  logic [3:0] div_bcd_h,
    input  logic [3:0] div_bcd_l,
    output logic [2:0] ack,
    output logic       range_err,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       busy
);

    // The settle counter loads SETTLE-1 and counts down to zero.
    localparam int            CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
    localparam logic [6:0]    MAX_7    = 7'(MAX_VAL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    chan_q, chan_d;
    logic [5:0]    operand_q, operand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    ack_q, ack_d;
    logic          range_err_q, range_err_d;

    logic          capture;
    logic [1:0]    ptr_p1, ptr_p2, grant;
    logic [5:0]    grant_bin;
    logic          over_max;
    logic [23:0]   bcd_vec;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // Round-robin search: ptr first, then ptr+1, then ptr+2 (mod 3).
    always_comb begin
        ptr_p1 = inc3(ptr_q);
        ptr_p2 = inc3(ptr_p1);
        if (req[ptr_q]) begin
            grant = ptr_q;
        end else if (req[ptr_p1]) begin
            grant = ptr_p1;
        end else begin
            grant = ptr_p2;
        end
        case (grant)
            2'd0:    grant_bin = bin_sec;
            2'd1:    grant_bin = bin_min;
            default: grant_bin = bin_hour;
        endcase
    end

    assign over_max = {1'b0, operand_q} > MAX_7;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        chan_d      = chan_q;
        operand_d   = operand_q;
        cnt_d       = cnt_q;
        ack_d       = 3'b000;
        range_err_d = 1'b0;
        capture     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    chan_d    = grant;
                    operand_d = grant_bin;
                    cnt_d     = CNT_LOAD;
                    state_d   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (cnt_q == '0) begin
                    // Last settle cycle: the divider output is stable now.
                    ack_d       = 3'b001 << chan_q;
                    range_err_d = over_max;
                    capture     = !over_max;
                    state_d     = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK: begin
                ptr_d   = inc3(chan_q);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 2'd0;
            chan_q      <= 2'd0;
            operand_q   <= 6'd0;
            cnt_q       <= '0;
            ack_q       <= 3'b000;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            chan_q      <= chan_d;
            operand_q   <= operand_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            range_err_q <= range_err_d;
        end
    end

    // One result register per channel; written only on a successful capture.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_result
            logic [7:0] res_q, res_d;
            always_comb begin
                res_d = res_q;
                if (capture && (chan_q == 2'(gi))) begin
                    res_d = {div_bcd_h, div_bcd_l};
                end
            end
            always_ff @(posedge clk) begin
                if (reset) begin
                    res_q <= 8'h00;
                end else begin
                    res_q <= res_d;
                end
            end
            assign bcd_vec[gi*8 +: 8] = res_q;
        end
    endgenerate

    assign div_bin   = operand_q;
    assign ack       = ack_q;
    assign range_err = range_err_q;
    assign sec_bcd   = bcd_vec[7:0];
    assign min_bcd   = bcd_vec[15:8];
    assign hour_bcd  = bcd_vec[23:16];
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bcd_share_ctrl.sv
module tb_bcd_share_ctrl;

    logic       clk;
    int         errors;
    int         checks;

    // Instance with SETTLE=1
    logic       reset;
    logic [2:0] req;
    logic [5:0] bin_sec, bin_min, bin_hour;
    logic [5:0] div_bin;
    logic [3:0] div_bcd_h, div_bcd_l;
    logic [2:0] ack;
    logic       range_err;
    logic [7:0] sec_bcd, min_bcd, hour_bcd;
    logic       busy;

    // Instance with SETTLE=3
    logic       rst3;
    logic [2:0] req3;
    logic [5:0] bin_sec3, bin_min3, bin_hour3;
    logic [5:0] div_bin3;
    logic [3:0] div_bcd_h3, div_bcd_l3;
    logic [2:0] ack3;
    logic       range_err3;
    logic [7:0] sec_bcd3, min_bcd3, hour_bcd3;
    logic       busy3;

    // Divider models
    assign div_bcd_h  = 4'(div_bin / 6'd10);
    assign div_bcd_l  = 4'(div_bin % 6'd10);
    assign div_bcd_h3 = 4'(div_bin3 / 6'd10);
    assign div_bcd_l3 = 4'(div_bin3 % 6'd10);

    bcd_share_ctrl #(.SETTLE(1), .MAX_VAL(59)) dut (
        .clk(clk), .reset(reset), .req(req),
        .bin_sec(bin_sec), .bin_min(bin_min), .bin_hour(bin_hour),
        .div_bin(div_bin), .div_bcd_h(div_bcd_h), .div_bcd_l(div_bcd_l),
        .ack(ack), .range_err(range_err),
        .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .busy(busy)
    );

    bcd_share_ctrl #(.SETTLE(3), .MAX_VAL(59)) dut3 (
        .clk(clk), .reset(rst3), .req(req3),
        .bin_sec(bin_sec3), .bin_min(bin_min3), .bin_hour(bin_hour3),
        .div_bin(div_bin3), .div_bcd_h(div_bcd_h3), .div_bcd_l(div_bcd_l3),
        .ack(ack3), .range_err(range_err3),
        .sec_bcd(sec_bcd3), .min_bcd(min_bcd3), .hour_bcd(hour_bcd3), .busy(busy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle; sample 1 time unit after the active edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req   = 3'b000;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b expected 000", ack); end
        checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL reset_range_err: got %b expected 0", range_err); end
        checks++; if (div_bin !== 6'd0) begin errors++; $display("FAIL reset_div_bin: got %0d expected 0", div_bin); end
        checks++; if ({sec_bcd, min_bcd, hour_bcd} !== 24'h0) begin errors++; $display("FAIL reset_bcd: got %h expected 000000", {sec_bcd, min_bcd, hour_bcd}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if ({ack3, busy3, sec_bcd3} !== 12'h0) begin errors++; $display("FAIL reset3_outputs: got %h expected 000", {ack3, busy3, sec_bcd3}); end
        $display("txn reset: ack=%b busy=%b bcd=%h", ack, busy, {sec_bcd, min_bcd, hour_bcd});
    endtask

    task automatic test_single;
        bin_sec = 6'd37;
        req     = 3'b001;                          // cycle 0
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_c0: got %b expected 0", busy); end
        step();                                    // cycle 1
        checks++; if (div_bin !== 6'd37) begin errors++; $display("FAIL single_div_bin: got %0d expected 37", div_bin); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_c1: got %b expected 1", busy); end
        checks++; if (ack !== 3'b000) begin errors++; $display("FAIL single_ack_c1: got %b expected 000", ack); end
        step();                                    // cycle 2
        checks++; if (ack !== 3'b001) begin errors++; $display("FAIL single_ack_c2: got %b expected 001", ack); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_c2: got %b expected 1", busy); end
        checks++; if (sec_bcd !== 8'h37) begin errors++; $display("FAIL single_sec_bcd: got %h expected 37", sec_bcd); end
        req = 3'b000;
        step();                                    // cycle 3
        checks++; if ({ack, busy} !== 4'b0000) begin errors++; $display("FAIL single_idle_c3: got ack=%b busy=%b expected 000/0", ack, busy); end
        $display("txn single sec: sec_bcd=%h", sec_bcd);
    endtask

    task automatic test_all_three;
        logic [2:0] exp;
        do_reset();
        bin_sec  = 6'd59;
        bin_min  = 6'd0;
        bin_hour = 6'd23;
        req      = 3'b111;
        for (int c = 1; c <= 9; c++) begin
            step();
            exp = (c == 2) ? 3'b001 : (c == 5) ? 3'b010 : (c == 8) ? 3'b100 : 3'b000;
            checks++; if (ack !== exp) begin errors++; $display("FAIL all3_ack_c%0d: got %b expected %b", c, ack, exp); end
            req = req & ~exp;
        end
        checks++; if (sec_bcd !== 8'h59) begin errors++; $display("FAIL all3_sec_bcd: got %h expected 59", sec_bcd); end
        checks++; if (min_bcd !== 8'h00) begin errors++; $display("FAIL all3_min_bcd: got %h expected 00", min_bcd); end
        checks++; if (hour_bcd !== 8'h23) begin errors++; $display("FAIL all3_hour_bcd: got %h expected 23", hour_bcd); end
        $display("txn all three: sec=%h min=%h hour=%h", sec_bcd, min_bcd, hour_bcd);
    endtask

    task automatic test_fairness;
        logic [2:0] exp;
        do_reset();
        bin_sec  = 6'd5;
        bin_min  = 6'd33;
        bin_hour = 6'd12;
        req      = 3'b001;
        for (int c = 1; c <= 11; c++) begin
            step();
            if (c == 1) req = 3'b101;
            exp = (c == 2 || c == 8) ? 3'b001 : (c == 5 || c == 11) ? 3'b100 : 3'b000;
            checks++; if (ack !== exp) begin errors++; $display("FAIL fair_ack_c%0d: got %b expected %b", c, ack, exp); end
        end
        req = 3'b000;
        step();
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fair_busy_end: got %b expected 0", busy); end
        checks++; if (hour_bcd !== 8'h12) begin errors++; $display("FAIL fair_hour_bcd: got %h expected 12", hour_bcd); end
        $display("txn fairness: sec=%h hour=%h min=%h", sec_bcd, hour_bcd, min_bcd);
    endtask

    task automatic test_back_to_back;
        logic [2:0] exp;
        bin_min = 6'd7;
        req     = 3'b010;
        for (int c = 1; c <= 5; c++) begin
            step();
            exp = (c == 2 || c == 5) ? 3'b010 : 3'b000;
            checks++; if (ack !== exp) begin errors++; $display("FAIL b2b_ack_c%0d: got %b expected %b", c, ack, exp); end
            if (c == 5) req = 3'b000;
        end
        checks++; if (min_bcd !== 8'h07) begin errors++; $display("FAIL b2b_min_bcd: got %h expected 07", min_bcd); end
        step();
        $display("txn back to back: min=%h", min_bcd);
    endtask

    task automatic test_range;
        bin_min = 6'd42;
        req     = 3'b010;
        step();
        step();
        checks++; if ({ack, range_err} !== 4'b0100) begin errors++; $display("FAIL range_ok_ack: got ack=%b err=%b expected 010/0", ack, range_err); end
        checks++; if (min_bcd !== 8'h42) begin errors++; $display("FAIL range_ok_min: got %h expected 42", min_bcd); end
        req = 3'b000;
        step();                                    // IDLE
        bin_min = 6'd60;
        req     = 3'b010;
        step();                                    // GRANT
        checks++; if (div_bin !== 6'd60) begin errors++; $display("FAIL range_div_bin: got %0d expected 60", div_bin); end
        step();                                    // ACK
        checks++; if (ack !== 3'b010) begin errors++; $display("FAIL range_ack: got %b expected 010", ack); end
        checks++; if (range_err !== 1'b1) begin errors++; $display("FAIL range_err_pulse: got %b expected 1", range_err); end
        checks++; if (min_bcd !== 8'h42) begin errors++; $display("FAIL range_min_kept: got %h expected 42", min_bcd); end
        req = 3'b000;
        step();
        checks++; if ({ack, range_err} !== 4'b0000) begin errors++; $display("FAIL range_clear: got ack=%b err=%b expected 000/0", ack, range_err); end
        $display("txn range: min=%h", min_bcd);
    endtask

    task automatic test_hold;
        bin_min = 6'd45;
        req     = 3'b010;
        step();                                    // GRANT
        req     = 3'b000;
        bin_min = 6'd12;
        checks++; if (div_bin !== 6'd45) begin errors++; $display("FAIL hold_div_bin: got %0d expected 45", div_bin); end
        step();                                    // ACK
        checks++; if (ack !== 3'b010) begin errors++; $display("FAIL hold_ack: got %b expected 010", ack); end
        checks++; if (min_bcd !== 8'h45) begin errors++; $display("FAIL hold_min_bcd: got %h expected 45", min_bcd); end
        step();
        checks++; if ({ack, busy} !== 4'b0000) begin errors++; $display("FAIL hold_idle: got ack=%b busy=%b expected 000/0", ack, busy); end
        checks++; if (min_bcd !== 8'h45) begin errors++; $display("FAIL hold_min_after: got %h expected 45", min_bcd); end
        $display("txn hold: min=%h", min_bcd);
    endtask

    task automatic test_settle3;
        logic [2:0] exp;
        bin_sec3 = 6'd48;
        req3     = 3'b001;
        for (int c = 1; c <= 5; c++) begin
            step();
            exp = (c == 4) ? 3'b001 : 3'b000;
            checks++; if (ack3 !== exp) begin errors++; $display("FAIL s3_ack_c%0d: got %b expected %b", c, ack3, exp); end
            checks++; if (busy3 !== (c <= 4)) begin errors++; $display("FAIL s3_busy_c%0d: got %b expected %b", c, busy3, (c <= 4)); end
            if (c == 4) req3 = 3'b000;
        end
        checks++; if (sec_bcd3 !== 8'h48) begin errors++; $display("FAIL s3_sec_bcd: got %h expected 48", sec_bcd3); end
        $display("txn settle3 sec: sec_bcd=%h", sec_bcd3);
    endtask

    task automatic test_abort;
        bin_hour3 = 6'd17;
        req3      = 3'b100;                        // cycle 0
        step();                                    // cycle 1, first GRANT
        checks++; if ({busy3, div_bin3} !== {1'b1, 6'd17}) begin errors++; $display("FAIL abort_grant: got busy=%b div=%0d expected 1/17", busy3, div_bin3); end
        step();                                    // cycle 2, second GRANT
        rst3 = 1'b1;
        req3 = 3'b000;
        step();                                    // cycle 3
        rst3 = 1'b0;
        checks++; if ({busy3, ack3, range_err3, div_bin3} !== 11'd0) begin errors++; $display("FAIL abort_idle: got busy=%b ack=%b err=%b div=%0d expected all 0", busy3, ack3, range_err3, div_bin3); end
        checks++; if ({sec_bcd3, hour_bcd3} !== 16'h0) begin errors++; $display("FAIL abort_regs: got sec=%h hour=%h expected 00/00", sec_bcd3, hour_bcd3); end
        for (int c = 4; c <= 8; c++) begin
            step();
            checks++; if ({ack3, hour_bcd3} !== 11'd0) begin errors++; $display("FAIL abort_late_c%0d: got ack=%b hour=%h expected 000/00", c, ack3, hour_bcd3); end
        end
        $display("txn abort: ack=%b hour=%h", ack3, hour_bcd3);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        rst3      = 1'b1;
        req       = 3'b000;
        req3      = 3'b000;
        bin_sec   = 6'd0;
        bin_min   = 6'd0;
        bin_hour  = 6'd0;
        bin_sec3  = 6'd0;
        bin_min3  = 6'd0;
        bin_hour3 = 6'd0;
        step();
        step();
        rst3 = 1'b0;
        test_reset();
        test_single();
        test_all_three();
        test_fairness();
        test_back_to_back();
        test_range();
        test_hold();
        test_settle3();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
